// File: rtl/stepper_move_sequencer_if.sv
`default_nettype none
// ============================================================================
// stepper_move_sequencer_if : command/status bundle between register file and
// move sequencer.  Rev 1.0
// ============================================================================
interface stepper_move_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             step_out;
  logic             dir_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_done;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_ready, step_out, dir_out, busy, done, aborted, steps_done
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_ready, step_out, dir_out, busy, done, aborted, steps_done
  );
endinterface
`default_nettype wire

// File: rtl/stepper_move_sequencer.sv
`default_nettype none
// ============================================================================
// stepper_move_sequencer : one-move-at-a-time STEP/DIR pulse generator with
// guaranteed pulse width, DIR setup time and clean abort.  Rev 1.0
// ============================================================================
module stepper_move_sequencer #(
  parameter int CNT_W         = 32,
  parameter int DIV_W         = 32,
  parameter int STEP_HIGH_CYC = 100,
  parameter int DIR_SETUP_CYC = 50
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  stepper_move_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DIR_SETUP = 3'd1,
    S_STEP_HIGH = 3'd2,
    S_STEP_LOW  = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] C_HIGH       = DIV_W'(STEP_HIGH_CYC);
  localparam logic [DIV_W-1:0] C_HIGH_LAST  = DIV_W'(STEP_HIGH_CYC - 1);
  localparam logic [DIV_W-1:0] C_SETUP_LAST = DIV_W'(DIR_SETUP_CYC - 1);
  localparam logic [DIV_W-1:0] C_MIN_PERIOD = DIV_W'(2 * STEP_HIGH_CYC);

  state_t           state_q,      state_d;
  logic [DIV_W-1:0] timer_q,      timer_d;
  logic [DIV_W-1:0] low_last_q,   low_last_d;
  logic [CNT_W-1:0] target_q,     target_d;
  logic [CNT_W-1:0] steps_done_q, steps_done_d;
  logic             dir_q,        dir_d;
  logic             step_q,       step_d;
  logic             aborted_q,    aborted_d;
  logic             abort_pend_q, abort_pend_d;

  logic [DIV_W-1:0] eff_period;
  logic             last_step;

  assign eff_period = (bus.cmd_period < C_MIN_PERIOD) ? C_MIN_PERIOD : bus.cmd_period;
  assign last_step  = (steps_done_q + CNT_W'(1)) == target_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    low_last_d   = low_last_q;
    target_d     = target_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          target_d     = bus.cmd_steps;
          low_last_d   = eff_period - C_HIGH - DIV_W'(1);
          steps_done_d = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          timer_d      = '0;
          if (bus.cmd_steps == '0) begin
            state_d = S_FINISH;
          end else if (bus.cmd_dir != dir_q) begin
            dir_d   = bus.cmd_dir;
            state_d = S_DIR_SETUP;
          end else begin
            state_d = S_STEP_HIGH;
          end
        end
      end

      S_DIR_SETUP: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (timer_q == C_SETUP_LAST) begin
          timer_d = '0;
          state_d = S_STEP_HIGH;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end

      // An abort here is remembered so the pulse still gets its full width.
      S_STEP_HIGH: begin
        if (bus.abort) abort_pend_d = 1'b1;
        if (timer_q == C_HIGH_LAST) begin
          timer_d      = '0;
          steps_done_d = steps_done_q + CNT_W'(1);
          if (abort_pend_q || bus.abort) begin
            aborted_d = !last_step;
            state_d   = S_FINISH;
          end else begin
            state_d = S_STEP_LOW;
          end
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end

      S_STEP_LOW: begin
        if (timer_q == low_last_q) begin
          timer_d = '0;
          if (steps_done_q == target_q) begin
            state_d = S_FINISH;
          end else if (bus.abort) begin
            aborted_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            state_d = S_STEP_HIGH;
          end
        end else if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    step_d = (state_d == S_STEP_HIGH);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      low_last_q   <= '0;
      target_q     <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      low_last_q   <= low_last_d;
      target_q     <= target_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FINISH);
  assign bus.step_out   = step_q;
  assign bus.dir_out    = dir_q;
  assign bus.aborted    = aborted_q;
  assign bus.steps_done = steps_done_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_sequencer.sv
`default_nettype none
// ============================================================================
// tb_stepper_move_sequencer : directed table-driven bench for the move
// sequencer (STEP_HIGH_CYC=100, DIR_SETUP_CYC=50).  Rev 1.0
// ============================================================================
module tb_stepper_move_sequencer;

  localparam int LIMIT = 5000;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;

  stepper_move_sequencer_if #(.CNT_W(32), .DIV_W(32)) bus ();

  stepper_move_sequencer #(
    .CNT_W(32), .DIV_W(32), .STEP_HIGH_CYC(100), .DIR_SETUP_CYC(50)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] steps;
    logic        dir;
    logic [31:0] period;
    int          abort_k;
    bit          spam;
    int          e_pulses;
    int          e_first;
    int          e_space;
    int          e_done;
    int          e_dir_k;
    logic        e_dir;
    logic        e_ab;
    logic [31:0] e_sd;
  } vec_t;

  typedef struct {
    int          pulses, first, smin, smax, wmin, wmax, done_k, dir_k;
    bit          dir_glitch;
    logic        ab, ab_start, busy_done, busy_after, ready_after, dir_final;
    logic [31:0] sd, sd_start;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_move(input vec_t v, output res_t r);
    logic prev, dir0;
    int   last_rise, hw, k;
    r = '{default: 0};
    @(negedge ACLK);
    dir0           = bus.dir_out;
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = v.steps;
    bus.cmd_dir    = v.dir;
    bus.cmd_period = v.period;
    @(negedge ACLK);
    // Optionally keep a conflicting request asserted to prove it is dropped.
    bus.cmd_valid  = v.spam;
    bus.cmd_steps  = 32'd7;
    bus.cmd_dir    = ~v.dir;
    bus.cmd_period = 32'd999;
    prev = 1'b0; last_rise = 0; hw = 0;
    for (k = 1; k <= LIMIT; k++) begin
      if (k > 1) @(negedge ACLK);
      bus.abort = (v.abort_k != 0) && (k == v.abort_k);
      if (k == 1) begin
        r.sd_start = bus.steps_done;
        r.ab_start = bus.aborted;
      end
      if (bus.dir_out != dir0 && r.dir_k == 0) begin
        r.dir_k = k;
        if (bus.step_out) r.dir_glitch = 1'b1;
      end
      if (bus.step_out && !prev) begin
        r.pulses++;
        if (r.first == 0) r.first = k;
        else begin
          if (r.smin == 0 || (k - last_rise) < r.smin) r.smin = k - last_rise;
          if ((k - last_rise) > r.smax) r.smax = k - last_rise;
        end
        last_rise = k;
        hw = 0;
      end
      if (bus.step_out) hw++;
      if (!bus.step_out && prev) begin
        if (r.wmin == 0 || hw < r.wmin) r.wmin = hw;
        if (hw > r.wmax) r.wmax = hw;
      end
      prev = bus.step_out;
      if (bus.done) begin
        bus.cmd_valid = 1'b0;
        r.done_k    = k;
        r.ab        = bus.aborted;
        r.sd        = bus.steps_done;
        r.busy_done = bus.busy;
        r.dir_final = bus.dir_out;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    @(negedge ACLK);
    r.busy_after  = bus.busy;
    r.ready_after = bus.cmd_ready;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    res_t r;
    run_move(v, r);
    chk({tag, " pulses"},     r.pulses, v.e_pulses);
    chk({tag, " first_rise"}, r.first,  v.e_first);
    if (v.e_pulses > 0) begin
      chk({tag, " width_min"}, r.wmin, 100);
      chk({tag, " width_max"}, r.wmax, 100);
    end
    if (v.e_pulses > 1) begin
      chk({tag, " spacing_min"}, r.smin, v.e_space);
      chk({tag, " spacing_max"}, r.smax, v.e_space);
    end
    chk({tag, " done_cycle"},   r.done_k,      v.e_done);
    chk({tag, " dir_change"},   r.dir_k,       v.e_dir_k);
    chk({tag, " dir_glitch"},   r.dir_glitch,  0);
    chk({tag, " dir_out"},      r.dir_final,   v.e_dir);
    chk({tag, " aborted"},      r.ab,          v.e_ab);
    chk({tag, " steps_done"},   r.sd,          v.e_sd);
    chk({tag, " sd_cleared"},   r.sd_start,    0);
    chk({tag, " ab_cleared"},   r.ab_start,    0);
    chk({tag, " busy_at_done"}, r.busy_done,   1);
    chk({tag, " busy_after"},   r.busy_after,  0);
    chk({tag, " ready_after"},  r.ready_after, 1);
  endtask

  vec_t vecs [7];
  vec_t hv;

  initial begin
    // steps dir period abort spam | pulses first space done dir_k dir ab sd
    vecs[0] = '{32'd3, 1'b0, 32'd400, 0, 1'b0, 3,  1, 400, 1201, 0, 1'b0, 1'b0, 32'd3};
    vecs[1] = '{32'd1, 1'b1, 32'd300, 0, 1'b0, 1, 51,   0,  351, 1, 1'b1, 1'b0, 32'd1};
    vecs[2] = '{32'd1, 1'b1, 32'd300, 0, 1'b0, 1,  1,   0,  301, 0, 1'b1, 1'b0, 32'd1};
    vecs[3] = '{32'd2, 1'b1, 32'd50,  0, 1'b0, 2,  1, 200,  401, 0, 1'b1, 1'b0, 32'd2};
    vecs[4] = '{32'd0, 1'b0, 32'd400, 0, 1'b0, 0,  0,   0,    1, 0, 1'b1, 1'b0, 32'd0};
    vecs[5] = '{32'd2, 1'b0, 32'd200, 0, 1'b0, 2, 51, 200,  451, 1, 1'b0, 1'b0, 32'd2};
    vecs[6] = '{32'd1, 1'b0, 32'd201, 0, 1'b0, 1,  1,   0,  202, 0, 1'b0, 1'b0, 32'd1};

    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;

    repeat (2) @(negedge ACLK);
    chk("reset step_out",   bus.step_out,   0);
    chk("reset dir_out",    bus.dir_out,    0);
    chk("reset busy",       bus.busy,       0);
    chk("reset done",       bus.done,       0);
    chk("reset aborted",    bus.aborted,    0);
    chk("reset steps_done", bus.steps_done, 0);
    chk("reset cmd_ready",  bus.cmd_ready,  1);
    ARESETN = 1'b1;
    @(negedge ACLK);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort on the 30th cycle of the 4th pulse while a stray request is held.
    hv = '{32'd10, 1'b0, 32'd400, 1230, 1'b1, 4, 1, 400, 1301, 0, 1'b0, 1'b1, 32'd4};
    apply_vec(hv, "abort_high");

    // Abort during direction setup ends the move with no pulse.
    hv = '{32'd5, 1'b1, 32'd400, 10, 1'b0, 0, 0, 0, 11, 1, 1'b1, 1'b1, 32'd0};
    apply_vec(hv, "abort_setup");

    // Abort on the final low cycle of the last step: normal completion wins.
    hv = '{32'd1, 1'b1, 32'd300, 300, 1'b0, 1, 1, 0, 301, 0, 1'b1, 1'b0, 32'd1};
    apply_vec(hv, "abort_last");

    @(negedge ACLK);
    bus.abort = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("idle_abort busy",    bus.busy, 0);
    chk("idle_abort done",    bus.done, 0);
    chk("idle_abort aborted", bus.aborted, 0);
    bus.abort = 1'b0;

    // Reset asserted in the middle of a STEP high phase.
    @(negedge ACLK);
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = 32'd5;
    bus.cmd_dir    = 1'b1;
    bus.cmd_period = 32'd400;
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    repeat (48) @(negedge ACLK);
    chk("pre_reset step_out", bus.step_out, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_reset step_out",   bus.step_out,   0);
    chk("mid_reset dir_out",    bus.dir_out,    0);
    chk("mid_reset busy",       bus.busy,       0);
    chk("mid_reset done",       bus.done,       0);
    chk("mid_reset aborted",    bus.aborted,    0);
    chk("mid_reset steps_done", bus.steps_done, 0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_reset cmd_ready", bus.cmd_ready, 1);

    hv = '{32'd2, 1'b0, 32'd250, 0, 1'b0, 2, 1, 250, 501, 0, 1'b0, 1'b0, 32'd2};
    apply_vec(hv, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
